lfsr_operand_gen: RTL and testbench
===================================

# lfsr_operand_gen

Pseudo-random operand source that sits directly upstream of the 8-bit accumulator in the LFSR lab datapath. It generates a burst of N operands from an 8-bit maximal-length Fibonacci LFSR and drives them onto the accumulator's `a` input. It also drives the accumulator's synchronous clear and keeps a reference running sum, so a bench can compare the accumulator output against `exp_sum` beat by beat.

## Interface
Parameters:
- none; width fixed at 8, polynomial fixed at x^8+x^6+x^5+x^4+1.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `seed_load`  in  1  load `seed` into LFSR state (IDLE only).
- `seed`  in  8  seed value; 8'h00 is replaced by 8'h01.
- `start`  in  1  begin a burst (IDLE only).
- `len`  in  8  burst length, sampled at accepted `start`; 0 means 256.
- `hold`  in  1  stall during RUN.
- `a`  out  8  operand to accumulator; 8'h00 whenever `a_valid`=0.
- `a_valid`  out  1  `a` carries a beat this cycle.
- `acc_clr`  out  1  one-cycle clear pulse, wired to the accumulator `rst`.
- `busy`  out  1  high in CLR, RUN and DONE.
- `done`  out  1  one-cycle pulse at end of burst.
- `count`  out  9  beats emitted in the current or last burst.
- `exp_sum`  out  8  mod-256 sum of beats emitted since the last CLR.

## Operation
- LFSR next state: {q[6:0], q[7]^q[5]^q[4]^q[3]}. Period is 255; the all-zero state is never reachable.
- Seed 8'h01 produces the sequence 01, 02, 04, 08, 11, 23, …
- FSM states: IDLE, CLR, RUN, DONE.
- IDLE:
  - `seed_load`=1 writes the seed into the LFSR state.
  - `start`=1 latches `len` (0 is taken as 256), clears `count` and `exp_sum`, and moves to CLR.
  - If `seed_load` and `start` occur together, both take effect, and the first beat uses the new seed.
- CLR: `acc_clr`=1 and `a_valid`=0 for exactly one cycle, then move to RUN.
- RUN, `hold`=0:
  - `a` = LFSR state and `a_valid`=1.
  - The LFSR advances, `count` increments, and `exp_sum` is updated to `exp_sum` + `a` (mod 256).
  - After beat N the FSM moves to DONE.
- RUN, `hold`=1: `a_valid`=0, `a`=0, and the LFSR, `count` and `exp_sum` are frozen. The accumulator adds zero, so its sum is preserved.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Retained values after a burst:
  - The LFSR state is kept, so the next burst continues the sequence.
  - `count` and `exp_sum` hold their values until the next accepted `start`.
- Ignored inputs: `start` and `seed_load` outside IDLE; `hold` outside RUN.
- Reset values:
  - FSM = IDLE and LFSR = 8'h01.
  - `a`=0, `a_valid`=0, `acc_clr`=0, `busy`=0, `done`=0, `count`=0, `exp_sum`=0.
- Reset mid-burst aborts immediately to the reset values. No `done` is produced, and the accumulator is not cleared by this block.

## Timing
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- `start` accepted at edge t puts the FSM in CLR during cycle t+1, with `acc_clr`=1.
- Beats occupy cycles t+2 … t+1+N plus the number of hold cycles.
- `done` is asserted in the cycle after the last beat. At that point `exp_sum` and the accumulator's registered sum are equal.
- `busy` is high from t+1 through the DONE cycle inclusive.
- Back-to-back bursts: the earliest next `start` is accepted in the IDLE cycle after DONE. The minimum gap is 1 idle cycle.

## Test plan
- Basic burst: reset, then `seed_load`=1 with `seed`=8'h01, then `start` with `len`=4. Required response:
  - `acc_clr` pulses once.
  - `a` = 01, 02, 04, 08 on consecutive cycles.
  - `done` one cycle later, with `exp_sum`=8'h0F, `count`=4, and the accumulator sum = 8'h0F.
- Zero seed and simultaneous load/start: `seed`=8'h00 with `seed_load` and `start` in the same cycle, `len`=2 → `a` = 01, 02; `exp_sum`=8'h03.
- Full-length burst: `len`=0 with seed 8'h01 → 256 beats; the last beat is 01 again; `count`=256; `exp_sum`=8'h81.
- Hold: `len`=3 with `hold` high for 2 cycles after the first beat →
  - `a` = 01, 00, 00, 02, 04 with `a_valid` = 1, 0, 0, 1, 1.
  - `done` at t+7; `exp_sum`=8'h07.
- Continuation and ignored inputs:
  - A second `start` with `len`=2 after the first burst → beats 11, 23 (the sequence continues from the first burst).
  - `start` and `seed_load` pulsed mid-burst have no effect.
- Reset mid-burst: `rst` asserted during beat 2 → the next cycle shows IDLE, `a`=0, `busy`=0, LFSR=8'h01, and no `done`.

Source files
------------

// File: rtl/lfsr_operand_gen.sv
// Burst operand source for the 8-bit accumulator: x^8+x^6+x^5+x^4+1 Fibonacci LFSR
// with accumulator clear pulse and a reference mod-256 running sum; all outputs registered.
module lfsr_operand_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       seed_load_i,
  input  logic [7:0] seed_i,
  input  logic       start_i,
  input  logic [7:0] len_i,
  input  logic       hold_i,
  output logic [7:0] a_o,
  output logic       a_valid_o,
  output logic       acc_clr_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [8:0] count_o,
  output logic [7:0] exp_sum_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CLR  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d, lfsr_next;
  logic [8:0] len_q, len_d;
  logic [8:0] count_q, count_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] a_q, a_d;
  logic       a_valid_q, a_valid_d;
  logic       beat;

  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // beat=1 means the cycle after this edge presents lfsr_q on a_o; hold is
  // sampled at the edge that would launch the next beat, keeping a_o registered.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    len_d   = len_q;
    count_d = count_q;
    sum_d   = sum_q;
    beat    = 1'b0;
    case (state_q)
      IDLE: begin
        if (seed_load_i) begin
          lfsr_d = (seed_i == 8'h00) ? 8'h01 : seed_i;
        end
        if (start_i) begin
          len_d   = (len_i == 8'h00) ? 9'd256 : {1'b0, len_i};
          count_d = 9'd0;
          sum_d   = 8'h00;
          state_d = CLR;
        end
      end
      CLR: begin
        state_d = RUN;
        beat    = 1'b1;
      end
      RUN: begin
        if (count_q == len_q) begin
          state_d = DONE;
        end else begin
          beat = ~hold_i;
        end
      end
      default: state_d = IDLE;
    endcase
    if (beat) begin
      lfsr_d  = lfsr_next;
      count_d = count_q + 9'd1;
      sum_d   = sum_q + lfsr_q;
    end
  end

  assign a_valid_d = beat;
  assign a_d       = beat ? lfsr_q : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lfsr_q    <= 8'h01;
      len_q     <= 9'd0;
      count_q   <= 9'd0;
      sum_q     <= 8'h00;
      a_q       <= 8'h00;
      a_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      len_q     <= len_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
    end
  end

  assign a_o       = a_q;
  assign a_valid_o = a_valid_q;
  assign acc_clr_o = (state_q == CLR);
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign count_o   = count_q;
  assign exp_sum_o = sum_q;

endmodule

// File: tb/tb_lfsr_operand_gen.sv
// Directed bench for lfsr_operand_gen with a behavioural accumulator on a/acc_clr.
module tb_lfsr_operand_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_load_i;
  logic [7:0] seed_i;
  logic       start_i;
  logic [7:0] len_i;
  logic       hold_i;
  logic [7:0] a_o;
  logic       a_valid_o;
  logic       acc_clr_o;
  logic       busy_o;
  logic       done_o;
  logic [8:0] count_o;
  logic [7:0] exp_sum_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] acc;

  lfsr_operand_gen dut (
    .clk(clk), .rst(rst),
    .seed_load_i(seed_load_i), .seed_i(seed_i),
    .start_i(start_i), .len_i(len_i), .hold_i(hold_i),
    .a_o(a_o), .a_valid_o(a_valid_o), .acc_clr_o(acc_clr_o),
    .busy_o(busy_o), .done_o(done_o), .count_o(count_o), .exp_sum_o(exp_sum_o)
  );

  always #5 clk = ~clk;

  // downstream accumulator: sync clear, adds a every cycle
  always @(posedge clk) begin
    if (acc_clr_o) acc <= 8'h00;
    else           acc <= acc + a_o;
  end

  typedef struct {
    logic       ld;
    logic [7:0] seed;
    logic       same;
    logic       poke;
    logic [7:0] len;
    int         nbeats;
    logic [7:0] first;
    logic [7:0] last;
    logic [7:0] sum;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int nb, cyc, extra_clr, bad_a;
    logic [7:0] first, last;
    string tag;
    tag = $sformatf("v%0d", idx);
    nb = 0; cyc = 0; extra_clr = 0; bad_a = 0; first = 8'h00; last = 8'h00;
    if (v.ld && !v.same) begin
      seed_load_i = 1'b1; seed_i = v.seed;
      tick();
      seed_load_i = 1'b0;
    end
    if (v.ld && v.same) begin
      seed_load_i = 1'b1; seed_i = v.seed;
    end
    start_i = 1'b1; len_i = v.len;
    tick();
    start_i = 1'b0; seed_load_i = 1'b0;
    chk({tag, " acc_clr"}, acc_clr_o, 1);
    chk({tag, " clr a_valid"}, a_valid_o, 0);
    while (!done_o && cyc < 400) begin
      if (a_valid_o) begin
        if (nb == 0) first = a_o;
        last = a_o;
        nb++;
      end else if (a_o != 8'h00) begin
        bad_a++;
      end
      if (cyc > 0 && acc_clr_o) extra_clr++;
      start_i     = v.poke && (cyc == 1);
      seed_load_i = v.poke && (cyc == 1);
      seed_i      = 8'hAA;
      len_i       = 8'd7;
      tick();
      cyc++;
    end
    start_i = 1'b0; seed_load_i = 1'b0;
    chk({tag, " done seen"}, done_o, 1);
    chk({tag, " done cycle"}, cyc, v.nbeats + 1);
    chk({tag, " beats"}, nb, v.nbeats);
    chk({tag, " first"}, first, v.first);
    chk({tag, " last"}, last, v.last);
    chk({tag, " exp_sum"}, exp_sum_o, v.sum);
    chk({tag, " count"}, count_o, v.nbeats);
    chk({tag, " acc"}, acc, v.sum);
    chk({tag, " busy in done"}, busy_o, 1);
    chk({tag, " extra clr / nonzero idle a"}, extra_clr + bad_a, 0);
    tick();
    chk({tag, " done one cycle"}, done_o, 0);
    chk({tag, " idle busy"}, busy_o, 0);
    chk({tag, " count held"}, count_o, v.nbeats);
  endtask

  initial begin
    logic [7:0] ha [5];
    logic       hv [5];
    int dn;
    vec_t rv;

    vecs[0] = '{ld:1'b1, seed:8'h01, same:1'b0, poke:1'b0, len:8'd4, nbeats:4,   first:8'h01, last:8'h08, sum:8'h0F};
    vecs[1] = '{ld:1'b0, seed:8'h00, same:1'b0, poke:1'b1, len:8'd2, nbeats:2,   first:8'h11, last:8'h23, sum:8'h34};
    vecs[2] = '{ld:1'b1, seed:8'h00, same:1'b1, poke:1'b0, len:8'd2, nbeats:2,   first:8'h01, last:8'h02, sum:8'h03};
    vecs[3] = '{ld:1'b1, seed:8'h01, same:1'b0, poke:1'b0, len:8'd0, nbeats:256, first:8'h01, last:8'h01, sum:8'h81};

    rst = 1'b1; seed_load_i = 1'b0; seed_i = 8'h00; start_i = 1'b0; len_i = 8'h00; hold_i = 1'b0;
    tick(); tick();
    chk("rst a", a_o, 0);
    chk("rst a_valid", a_valid_o, 0);
    chk("rst acc_clr", acc_clr_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst count", count_o, 0);
    chk("rst exp_sum", exp_sum_o, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // hold for two cycles after the first beat
    seed_load_i = 1'b1; seed_i = 8'h01;
    tick();
    seed_load_i = 1'b0; start_i = 1'b1; len_i = 8'd3;
    tick();
    start_i = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      ha[k] = a_o; hv[k] = a_valid_o;
      hold_i = (k < 2);
      tick();
    end
    hold_i = 1'b0;
    chk("hold a0", ha[0], 8'h01); chk("hold v0", hv[0], 1);
    chk("hold a1", ha[1], 8'h00); chk("hold v1", hv[1], 0);
    chk("hold a2", ha[2], 8'h00); chk("hold v2", hv[2], 0);
    chk("hold a3", ha[3], 8'h02); chk("hold v3", hv[3], 1);
    chk("hold a4", ha[4], 8'h04); chk("hold v4", hv[4], 1);
    chk("hold done t+7", done_o, 1);
    chk("hold exp_sum", exp_sum_o, 8'h07);
    chk("hold acc", acc, 8'h07);
    tick();

    // reset during beat 2
    start_i = 1'b1; len_i = 8'd4;
    tick();
    start_i = 1'b0;
    tick(); tick();
    chk("pre-rst beat2 valid", a_valid_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst a", a_o, 0);
    chk("midrst a_valid", a_valid_o, 0);
    chk("midrst busy", busy_o, 0);
    chk("midrst count", count_o, 0);
    chk("midrst exp_sum", exp_sum_o, 0);
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      if (done_o || busy_o) dn++;
      tick();
    end
    chk("midrst no done", dn, 0);
    rv = '{ld:1'b0, seed:8'h00, same:1'b0, poke:1'b0, len:8'd1, nbeats:1, first:8'h01, last:8'h01, sum:8'h01};
    run_vec(rv, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
